// File: rtl/fifo_led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_led_pkg
// Description : Shared types and constants for the FIFO status LED block.
//               led_state_t encodes the blink sequencer states; ERR_* are
//               the bit masks of the latched fault code.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_led_pkg;

    typedef enum logic [1:0] {
        HEARTBEAT = 2'd0,
        FLASH_ON  = 2'd1,
        FLASH_OFF = 2'd2,
        GAP       = 2'd3
    } led_state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RDATA = 2'b01;
    localparam logic [1:0] ERR_STALL = 2'b10;

endpackage
`default_nettype wire

// File: rtl/led_sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : led_sync_bit
// Description : Multi-flop synchroniser for one asynchronous level onto
//               led_clk. All flops reset asynchronously to 0.
// Ports       : led_clk  - destination clock
//               sys_rst  - asynchronous active-high reset
//               async_i  - level from a foreign clock domain
//               sync_o   - synchronised level, SYNC_STAGE cycles later
// Revision    : 1.0 - initial release
// ============================================================================
module led_sync_bit
    import fifo_led_pkg::*;
#(
    parameter int SYNC_STAGE = 2
) (
    input  logic led_clk,
    input  logic sys_rst,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGE-1:0] r_sync;

    always_ff @(posedge led_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGE-2:0], async_i};
        end
    end

    assign sync_o = r_sync[SYNC_STAGE-1];

endmodule
`default_nettype wire

// File: rtl/fifo_status_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_status_led_ctrl
// Description : Status LED stage for the async FIFO demo. Resynchronises the
//               read-error / full / empty flags, latches a 2-bit fault code
//               and drives a heartbeat or repeating blink-code LED plus the
//               full/empty indicator LEDs.
// Build macro : LED_PULSE_STRETCH_EN - stretch led_full_o / led_empty_o to at
//               least STRETCH_TICKS ticks; otherwise a plain 1-cycle register.
// Ports       : led_clk, sys_rst (async, active-high)
//               rdata_error_i, fifo_full_i, fifo_empty_i - async inputs
//               clear_i      - synchronous clear of the latched fault code
//               led_status_o - heartbeat / blink code
//               led_full_o, led_empty_o - indicator LEDs
//               err_code_o   - bit0 read mismatch, bit1 full stall
//               tick_o       - one-cycle prescaler strobe
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_status_led_ctrl
    import fifo_led_pkg::*;
#(
    parameter int SYNC_STAGE    = 2,
    parameter int TICK_DIV      = 20,
    parameter int GAP_TICKS     = 4,
    parameter int FULL_TIMEOUT  = 8,
    parameter int STRETCH_TICKS = 2
) (
    input  logic       led_clk,
    input  logic       sys_rst,
    input  logic       rdata_error_i,
    input  logic       fifo_full_i,
    input  logic       fifo_empty_i,
    input  logic       clear_i,
    output logic       led_status_o,
    output logic       led_full_o,
    output logic       led_empty_o,
    output logic [1:0] err_code_o,
    output logic       tick_o
);

    localparam int c_frun_w = $clog2(FULL_TIMEOUT + 1);
    localparam int c_gap_w  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [c_frun_w-1:0] c_full_max = c_frun_w'(FULL_TIMEOUT);
    localparam logic [c_gap_w-1:0]  c_gap_load = c_gap_w'(GAP_TICKS - 1);

    logic w_s_rdata;
    logic w_s_full;
    logic w_s_empty;

    led_sync_bit #(.SYNC_STAGE(SYNC_STAGE)) u_sync_rdata (
        .led_clk (led_clk), .sys_rst (sys_rst),
        .async_i (rdata_error_i), .sync_o (w_s_rdata)
    );
    led_sync_bit #(.SYNC_STAGE(SYNC_STAGE)) u_sync_full (
        .led_clk (led_clk), .sys_rst (sys_rst),
        .async_i (fifo_full_i), .sync_o (w_s_full)
    );
    led_sync_bit #(.SYNC_STAGE(SYNC_STAGE)) u_sync_empty (
        .led_clk (led_clk), .sys_rst (sys_rst),
        .async_i (fifo_empty_i), .sync_o (w_s_empty)
    );

    // Prescaler: the strobe is the all-ones count, so it is 0 out of reset.
    logic [TICK_DIV-1:0] r_presc;
    logic                w_tick;

    always_ff @(posedge led_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + TICK_DIV'(1);
        end
    end

    assign w_tick = &r_presc;
    assign tick_o = w_tick;

    // Stall detector and sticky fault code. Clear wins over any set in the
    // same cycle; a source that is still active re-sets its bit next cycle.
    logic [c_frun_w-1:0] r_full_run;
    logic [1:0]          r_err;
    logic [1:0]          w_err_set;

    assign w_err_set = (w_s_rdata ? ERR_RDATA : ERR_NONE)
                     | ((r_full_run == c_full_max) ? ERR_STALL : ERR_NONE);

    always_ff @(posedge led_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_full_run <= '0;
            r_err      <= ERR_NONE;
        end else begin
            if (clear_i || !w_s_full) begin
                r_full_run <= '0;
            end else if (w_tick && (r_full_run != c_full_max)) begin
                r_full_run <= r_full_run + c_frun_w'(1);
            end

            if (clear_i) begin
                r_err <= ERR_NONE;
            end else begin
                r_err <= r_err | w_err_set;
            end
        end
    end

    assign err_code_o = r_err;

    // Blink sequencer. pulse_cnt is loaded from the fault code only at frame
    // start, so code changes mid-frame only show from the next frame.
    led_state_t       r_state,  w_state_nxt;
    logic             r_led,    w_led_nxt;
    logic [1:0]       r_pulse,  w_pulse_nxt;
    logic [c_gap_w-1:0] r_gap,  w_gap_nxt;

    always_ff @(posedge led_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= HEARTBEAT;
            r_led   <= 1'b0;
            r_pulse <= 2'd0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_led   <= w_led_nxt;
            r_pulse <= w_pulse_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_led_nxt   = r_led;
        w_pulse_nxt = r_pulse;
        w_gap_nxt   = r_gap;
        if (w_tick) begin
            case (r_state)
                HEARTBEAT: begin
                    if (r_err != ERR_NONE) begin
                        w_state_nxt = FLASH_ON;
                        w_led_nxt   = 1'b1;
                        w_pulse_nxt = r_err;
                    end else begin
                        w_led_nxt   = ~r_led;
                    end
                end
                FLASH_ON: begin
                    w_state_nxt = FLASH_OFF;
                    w_led_nxt   = 1'b0;
                    w_pulse_nxt = r_pulse - 2'd1;
                end
                FLASH_OFF: begin
                    if (r_pulse != 2'd0) begin
                        w_state_nxt = FLASH_ON;
                        w_led_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = GAP;
                        w_led_nxt   = 1'b0;
                        w_gap_nxt   = c_gap_load;
                    end
                end
                GAP: begin
                    w_led_nxt = 1'b0;
                    if (r_gap != '0) begin
                        w_gap_nxt = r_gap - c_gap_w'(1);
                    end else if (r_err != ERR_NONE) begin
                        w_state_nxt = FLASH_ON;
                        w_led_nxt   = 1'b1;
                        w_pulse_nxt = r_err;
                    end else begin
                        w_state_nxt = HEARTBEAT;
                    end
                end
                default: begin
                    w_state_nxt = HEARTBEAT;
                    w_led_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign led_status_o = r_led;

    // Indicator LEDs: index 0 = full, index 1 = empty.
    logic [1:0] r_led_fe;
    logic [1:0] w_lvl;

    assign w_lvl = {w_s_empty, w_s_full};

`ifdef LED_PULSE_STRETCH_EN
    // One extra tick is loaded because the first tick after a rise may land
    // almost immediately; this guarantees STRETCH_TICKS whole tick periods.
    localparam int c_str_w = $clog2(STRETCH_TICKS + 2);
    localparam logic [c_str_w-1:0] c_str_load = c_str_w'(STRETCH_TICKS + 1);

    logic [1:0]         r_lvl_prev;
    logic [c_str_w-1:0] r_str_cnt [2];

    always_ff @(posedge led_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_lvl_prev <= 2'b00;
            r_led_fe   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_str_cnt[i] <= '0;
            end
        end else begin
            r_lvl_prev <= w_lvl;
            for (int i = 0; i < 2; i++) begin
                if (w_lvl[i] && !r_lvl_prev[i]) begin
                    r_str_cnt[i] <= c_str_load;
                end else if (w_tick && (r_str_cnt[i] != '0)) begin
                    r_str_cnt[i] <= r_str_cnt[i] - c_str_w'(1);
                end
                r_led_fe[i] <= w_lvl[i] | (r_str_cnt[i] != '0);
            end
        end
    end
`else
    always_ff @(posedge led_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_led_fe <= 2'b00;
        end else begin
            r_led_fe <= w_lvl;
        end
    end
`endif

    assign led_full_o  = r_led_fe[0];
    assign led_empty_o = r_led_fe[1];

endmodule
`default_nettype wire
